// File: rtl/ms_skid_reg.sv
// ms_skid_reg: two-entry elastic pipeline register (main + skid) with registered handshake outputs.
// Define MS_SKID_FLUSH_EN to add the synchronous i_flush discard port.
module ms_skid_reg #(
    parameter int DATA_WIDTH = 32,
    parameter     REGNAME    = "defreg"
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
`ifdef MS_SKID_FLUSH_EN
    input  logic                  i_flush,
`endif
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_count
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t state;
    logic [DATA_WIDTH-1:0] main_q, skid_q;
    logic up, dn;
    assign up      = i_valid && o_ready;
    assign dn      = o_valid && i_ready;
    assign o_valid = state != EMPTY;
    assign o_ready = state != FULL;
    assign o_data  = main_q;
    assign o_count = state;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end
`ifdef MS_SKID_FLUSH_EN
        else if (i_flush) begin
            state <= EMPTY;
        end
`endif
        else begin
            case (state)
                EMPTY: if (up) begin
                    main_q <= i_data;
                    state  <= ONE;
                end
                ONE: if (up && dn) begin
                    main_q <= i_data;
                end else if (up) begin
                    skid_q <= i_data;
                    state  <= FULL;
                end else if (dn) begin
                    state  <= EMPTY;
                end
                FULL: if (dn) begin
                    main_q <= skid_q;
                    state  <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule
